// File: rtl/anpc_lev_sched_if.sv
// rtl/anpc_lev_sched_if.sv - modulator/leg-FSM side signal bundle for the ANPC level scheduler
interface anpc_lev_sched_if #(
  parameter int TW = 10,
  parameter int RW = 8
);
  logic          ce;
  logic          en;
  logic          fault;
  logic [1:0]    lev_req;
  logic [TW-1:0] dwell_min;
  logic          rot_en;
  logic [1:0]    comm_fix;
  logic [RW-1:0] rot_period;
  logic [1:0]    v_lev;
  logic [1:0]    comm_type;
  logic          ready;
  logic          lev_err;
  logic [2:0]    state_o;

  modport master (
    output ce, en, fault, lev_req, dwell_min, rot_en, comm_fix, rot_period,
    input  v_lev, comm_type, ready, lev_err, state_o
  );

  modport slave (
    input  ce, en, fault, lev_req, dwell_min, rot_en, comm_fix, rot_period,
    output v_lev, comm_type, ready, lev_err, state_o
  );
endinterface

// File: rtl/anpc_lev_sched.sv
// rtl/anpc_lev_sched.sv - dwell-limited 3L-ANPC level scheduler with zero-pass and commutation rotation
module anpc_lev_sched #(
  parameter int TW = 10,
  parameter int RW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  anpc_lev_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_ZPASS = 3'd2,
    S_SHDN  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    v_lev_q, v_lev_d;
  logic [TW-1:0] dwell_q;
  logic [1:0]    comm_q;
  logic [1:0]    comm_rot_q;   // commutation type handed out on the next rotated entry
  logic [RW-1:0] rot_cnt_q;
  logic [RW-1:0] rot_last;
  logic          lev_err_q, lev_err_d;
  logic          permit;
  logic          comm_upd;

  // I -> II -> III -> I; code 1 (IU) is never produced
  function automatic logic [1:0] rot_next(input logic [1:0] c);
    case (c)
      2'd0:    rot_next = 2'd2;
      2'd2:    rot_next = 2'd3;
      default: rot_next = 2'd0;
    endcase
  endfunction

  assign permit   = (dwell_q >= bus.dwell_min);
  assign rot_last = (bus.rot_period == '0) ? '0 : bus.rot_period - 1'b1;
  assign comm_upd = (v_lev_q == 2'd0) && (v_lev_d != 2'd0);

  // Next state / next level; fault overrides everything, then en=0, then lev_req
  always_comb begin
    state_d   = state_q;
    v_lev_d   = v_lev_q;
    lev_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        v_lev_d = 2'd0;
        if (bus.en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.en) begin
          state_d = S_SHDN;
        end else if (bus.lev_req == 2'd3) begin
          lev_err_d = 1'b1;
        end else if (permit && (bus.lev_req != v_lev_q)) begin
          if ((v_lev_q != 2'd0) && (bus.lev_req != 2'd0)) begin
            v_lev_d = 2'd0;          // P<->N must pass through zero
            state_d = S_ZPASS;
          end else begin
            v_lev_d = bus.lev_req;
          end
        end
      end
      S_ZPASS: begin
        if (!bus.en) begin
          state_d = S_SHDN;
        end else if (permit) begin
          state_d = S_RUN;
          v_lev_d = (bus.lev_req == 2'd3) ? 2'd0 : bus.lev_req;
        end
      end
      S_SHDN: begin
        if (bus.en) begin
          state_d = S_RUN;
        end else if (permit) begin
          if (v_lev_q != 2'd0) v_lev_d = 2'd0;
          else                 state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        v_lev_d = 2'd0;
        if (!bus.en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        v_lev_d = 2'd0;
      end
    endcase
    if (bus.fault) begin
      state_d   = S_FAULT;
      v_lev_d   = 2'd0;
      lev_err_d = 1'b0;
    end
  end

  // State, dwell timer and commutation registers; fault and lev_err act on every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      v_lev_q    <= 2'd0;
      dwell_q    <= '0;
      comm_q     <= 2'd0;
      comm_rot_q <= 2'd0;
      rot_cnt_q  <= '0;
      lev_err_q  <= 1'b0;
    end else begin
      lev_err_q <= bus.ce & lev_err_d;
      if (!bus.rot_en) rot_cnt_q <= '0;
      if (bus.fault) begin
        state_q <= S_FAULT;
        v_lev_q <= 2'd0;
        dwell_q <= '0;
      end else if (bus.ce) begin
        state_q <= state_d;
        v_lev_q <= v_lev_d;
        if ((state_q == S_FAULT) || (v_lev_d != v_lev_q)) dwell_q <= '0;
        else if (dwell_q != '1)                           dwell_q <= dwell_q + 1'b1;
        if (comm_upd) begin
          if (bus.rot_en) begin
            comm_q <= comm_rot_q;
            if (rot_cnt_q >= rot_last) begin
              rot_cnt_q  <= '0;
              comm_rot_q <= rot_next(comm_rot_q);
            end else begin
              rot_cnt_q <= rot_cnt_q + 1'b1;
            end
          end else begin
            comm_q <= (bus.comm_fix == 2'd1) ? 2'd0 : bus.comm_fix;
          end
        end
      end
    end
  end

  assign bus.v_lev     = v_lev_q;
  assign bus.comm_type = comm_q;
  assign bus.ready     = (state_q == S_RUN) && permit;
  assign bus.lev_err   = lev_err_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_anpc_lev_sched.sv
// tb/tb_anpc_lev_sched.sv - self-checking bench for anpc_lev_sched
module tb_anpc_lev_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  anpc_lev_sched_if #(.TW(10), .RW(8)) bus ();

  anpc_lev_sched #(.TW(10), .RW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: states 0..4 as numbered in the level-scheduler description
  int m_st, m_v, m_dw, m_comm, m_ridx, m_rcnt;
  bit m_err;
  int seq [3] = '{0, 2, 3};

  task automatic m_reset();
    m_st = 0; m_v = 0; m_dw = 0; m_comm = 0; m_ridx = 0; m_rcnt = 0; m_err = 0;
  endtask

  task automatic m_step();
    int  req, nv, ns, per;
    bit  ok;
    req   = int'(bus.lev_req);
    ok    = (m_dw >= int'(bus.dwell_min));
    m_err = bus.ce && !bus.fault && bus.en && (m_st == 1) && (req == 3);
    if (!bus.rot_en) m_rcnt = 0;
    if (bus.fault) begin
      m_st = 4; m_v = 0; m_dw = 0;
    end else if (bus.ce) begin
      ns = m_st;
      nv = m_v;
      if (m_st == 4) begin
        nv = 0;
        if (!bus.en) ns = 0;
      end else if (m_st == 0) begin
        if (bus.en) ns = 1;
      end else if (!bus.en) begin
        if (m_st == 1 || m_st == 2) ns = 3;
        else if (ok && m_v != 0) nv = 0;
        else if (ok) ns = 0;
      end else if (m_st == 3) begin
        ns = 1;
      end else if (m_st == 2) begin
        if (ok) begin ns = 1; nv = (req == 3) ? 0 : req; end
      end else if (ok && req != 3 && req != m_v) begin
        if (m_v != 0 && req != 0) begin nv = 0; ns = 2; end
        else nv = req;
      end
      if (m_v == 0 && nv != 0) begin
        if (bus.rot_en) begin
          per = (bus.rot_period == 0) ? 1 : int'(bus.rot_period);
          m_comm = seq[m_ridx];
          m_rcnt++;
          if (m_rcnt >= per) begin m_rcnt = 0; m_ridx = (m_ridx + 1) % 3; end
        end else begin
          m_comm = (bus.comm_fix == 2'd1) ? 0 : int'(bus.comm_fix);
        end
      end
      if (m_st == 4 || nv != m_v) m_dw = 0;
      else if (m_dw < 1023) m_dw++;
      m_st = ns;
      m_v  = nv;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare every DUT output against the model at the falling edge
  task automatic tick();
    @(negedge clk);
    check("v_lev",     int'(bus.v_lev),     m_v);
    check("comm_type", int'(bus.comm_type), m_comm);
    check("ready",     int'(bus.ready),     int'(m_st == 1 && m_dw >= int'(bus.dwell_min)));
    check("lev_err",   int'(bus.lev_err),   int'(m_err));
    check("state",     int'(bus.state_o),   m_st);
  endtask

  int rot_exp [10] = '{0, 0, 2, 2, 3, 3, 0, 0, 2, 2};
  int seen2, prev_v, k;

  initial begin
    bus.ce = 1; bus.en = 0; bus.fault = 0; bus.lev_req = 0; bus.dwell_min = 4;
    bus.rot_en = 0; bus.comm_fix = 0; bus.rot_period = 2;
    tick(); tick();
    check("rst_v_lev", bus.v_lev, 0);
    check("rst_state", bus.state_o, 0);
    check("rst_comm", bus.comm_type, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_lev_err", bus.lev_err, 0);
    rst_n = 1;
    repeat (6) tick();

    // Enter RUN with dwell already satisfied, then a dwell-limited P->0
    bus.en = 1; bus.lev_req = 1;
    tick(); check("t1_run", bus.state_o, 1); check("t1_v0", bus.v_lev, 0);
    tick(); check("t1_v1", bus.v_lev, 1);
    tick(); tick();
    bus.lev_req = 0;
    tick(); check("t1_hold_d3", bus.v_lev, 1); check("t1_ready_d3", bus.ready, 0);
    tick(); check("t1_hold_d4", bus.v_lev, 1); check("t1_ready_d4", bus.ready, 1);
    tick(); check("t1_zero", bus.v_lev, 0);

    // Invalid request
    bus.dwell_min = 0; bus.lev_req = 3;
    tick(); check("t6_err", bus.lev_err, 1); check("t6_hold", bus.v_lev, 0);
    bus.lev_req = 0;
    tick(); check("t6_err_clr", bus.lev_err, 0);

    // Polarity reversal through ZPASS
    bus.dwell_min = 3; bus.lev_req = 1;
    repeat (8) tick();
    check("t2_p", bus.v_lev, 1);
    bus.lev_req = 2;
    tick(); check("t2_zpass", bus.state_o, 2); check("t2_zero", bus.v_lev, 0);
    seen2 = 0;
    for (int i = 0; i < 12 && seen2 == 0; i++) begin
      tick();
      if (bus.v_lev == 2) seen2 = 1;
    end
    check("t2_reached_n", seen2, 1);

    // Fault while dwell is short
    bus.dwell_min = 8;
    tick();
    bus.fault = 1;
    tick(); check("t4_v0", bus.v_lev, 0); check("t4_fault", bus.state_o, 4);
    bus.fault = 0; bus.en = 1;
    repeat (3) tick();
    check("t4_stay", bus.state_o, 4);
    bus.en = 0;
    tick(); check("t4_idle", bus.state_o, 0);

    // Rotation from a clean reset
    rst_n = 0; tick(); rst_n = 1;
    bus.dwell_min = 0; bus.rot_en = 1; bus.rot_period = 2; bus.en = 1; bus.lev_req = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.lev_req = 1; tick();
      check($sformatf("t3_rot%0d", i), bus.comm_type, rot_exp[i]);
      bus.lev_req = 0; tick();
    end
    bus.rot_en = 0; bus.comm_fix = 1; bus.lev_req = 1;
    tick(); check("t3_fix1", bus.comm_type, 0);

    // Shutdown with sparse ce
    bus.dwell_min = 2; bus.en = 0;
    for (int i = 0; i < 36; i++) begin
      bus.ce = (i % 3 == 0);
      tick();
    end
    check("t5_idle", bus.state_o, 0);
    check("t5_v0", bus.v_lev, 0);

    // Reset asserted mid-ZPASS
    bus.ce = 1; bus.en = 1; bus.dwell_min = 5; bus.comm_fix = 3; bus.lev_req = 1;
    repeat (14) tick();
    check("t5_comm3", bus.comm_type, 3);
    bus.lev_req = 2;
    tick(); check("t5_zpass", bus.state_o, 2);
    rst_n = 0;
    #1;
    check("t5_rst_state", bus.state_o, 0);
    check("t5_rst_comm", bus.comm_type, 0);
    check("t5_rst_v", bus.v_lev, 0);
    tick();
    rst_n = 1;

    // Randomized traffic against the model
    prev_v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        bus.dwell_min  = 10'($urandom_range(0, 5));
        bus.rot_en     = 1'($urandom_range(0, 1));
        bus.rot_period = 8'($urandom_range(0, 3));
        bus.comm_fix   = 2'($urandom_range(0, 3));
      end
      bus.ce      = ($urandom_range(0, 3) != 0);
      bus.fault   = ($urandom_range(0, 99) == 0);
      k           = $urandom_range(0, 99);
      bus.en      = (k >= 6);
      k           = $urandom_range(0, 15);
      bus.lev_req = (k < 5) ? 2'd0 : (k < 10) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
      rst_n       = ($urandom_range(0, 999) != 0);
      tick();
      if ((prev_v == 1 && bus.v_lev == 2) || (prev_v == 2 && bus.v_lev == 1))
        check("direct_pn", 1, 0);
      prev_v = int'(bus.v_lev);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
